// File: rtl/nios_pio_in_edge.sv
// Avalon-MM parallel-input slave: synchronised input, sticky per-bit edge capture, maskable level irq.
// Build option: define NIOS_PIO_IN_DEBOUNCE_EN to add a per-bit stability filter ahead of edge detection.
module nios_pio_in_edge #(
    parameter int WIDTH           = 12,
    parameter int SYNC_STAGES     = 2,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

`ifdef NIOS_PIO_IN_DEBOUNCE_EN
    localparam int PRIME_CYCLES = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
`else
    localparam int PRIME_CYCLES = SYNC_STAGES + 1;
`endif
    localparam int PW = $clog2(PRIME_CYCLES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0] sync, filt;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] det_raw, det, clr;
    logic [PW-1:0]    prime_q, prime_d;
    logic             primed;
    logic             irq_q, irq_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             wr_en;

    // read strobe does not gate data; reads have no side effects
    logic unused_inputs;
    assign unused_inputs = ^{read, writedata};

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = in_port;
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    end
    assign sync = sync_q[SYNC_STAGES-1];

`ifdef NIOS_PIO_IN_DEBOUNCE_EN
    logic [WIDTH-1:0][7:0] dcnt_q, dcnt_d;
    logic [WIDTH-1:0]      filt_q, filt_d;

    // counter runs only while sync holds a value different from filt
    always_comb begin
        dcnt_d = dcnt_q;
        filt_d = filt_q;
        for (int b = 0; b < WIDTH; b++) begin
            if (sync[b] == filt_q[b]) begin
                dcnt_d[b] = '0;
            end else if (dcnt_q[b] == 8'(DEBOUNCE_CYCLES - 1)) begin
                filt_d[b] = sync[b];
                dcnt_d[b] = '0;
            end else begin
                dcnt_d[b] = dcnt_q[b] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dcnt_q <= '0;
            filt_q <= '0;
        end else begin
            dcnt_q <= dcnt_d;
            filt_q <= filt_d;
        end
    end
    assign filt = filt_q;
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
    assign filt = sync;
`endif

    // hold off detection until the chain has flushed its reset zeros
    assign primed  = (prime_q == PW'(PRIME_CYCLES));
    assign prime_d = primed ? prime_q : prime_q + PW'(1);

    always_comb begin
        case (EDGE_TYPE)
            0:       det_raw = filt & ~prev_q;
            1:       det_raw = ~filt & prev_q;
            default: det_raw = filt ^ prev_q;
        endcase
    end

    assign det    = primed ? det_raw : '0;
    assign prev_d = filt;
    assign wr_en  = chipselect & write;

    always_comb begin
        clr    = '0;
        mask_d = mask_q;
        if (wr_en && address == 2'd3) clr    = writedata[WIDTH-1:0];
        if (wr_en && address == 2'd2) mask_d = writedata[WIDTH-1:0];
        cap_d = (cap_q & ~clr) | det;
        irq_d = |(cap_d & mask_d);
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            2'd0:    readdata_d[WIDTH-1:0] = filt;
            2'd2:    readdata_d[WIDTH-1:0] = mask_q;
            2'd3:    readdata_d[WIDTH-1:0] = cap_q;
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q     <= '0;
            prev_q     <= '0;
            cap_q      <= '0;
            mask_q     <= '0;
            prime_q    <= '0;
            irq_q      <= 1'b0;
            readdata_q <= '0;
        end else begin
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            cap_q      <= cap_d;
            mask_q     <= mask_d;
            prime_q    <= prime_d;
            irq_q      <= irq_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_nios_pio_in_edge.sv
// Bench for nios_pio_in_edge: three edge-type instances on one bus, table + directed + random vs reference model.
module tb_nios_pio_in_edge;
    localparam int W = 12;
    localparam int S = 2;
    localparam int D = 4;
`ifdef NIOS_PIO_IN_DEBOUNCE_EN
    localparam int DL = D;
`else
    localparam int DL = 0;
`endif
    localparam int LAT = S + DL + 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [1:0]      addr = '0;
    logic            cs = 1'b0, rd_s = 1'b0, wr = 1'b0;
    logic [31:0]     wd = '0;
    logic [W-1:0]    inp = '0;
    logic [2:0][31:0] rd_o;
    logic [2:0]      irq_o;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        nios_pio_in_edge #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(g), .DEBOUNCE_CYCLES(D)) u_dut (
            .clk(clk), .reset(reset), .address(addr), .chipselect(cs), .read(rd_s),
            .write(wr), .writedata(wd), .in_port(inp), .readdata(rd_o[g]), .irq(irq_o[g]));
    end

    int checks = 0, failures = 0;

    // reference model state
    logic [W-1:0] inq[$];
    logic [W-1:0] shq[$];
    logic [W-1:0] m_filt, m_prev, m_mask;
    logic [W-1:0] m_cap [3];
    logic         m_irq [3];
    logic [31:0]  m_rd  [3];
    int           m_edges;

    typedef struct {
        logic        cs;
        logic        wr;
        logic [1:0]  a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        irq;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] edge_of(input int t, input logic [W-1:0] f, input logic [W-1:0] p);
        case (t)
            0:       return f & ~p;
            1:       return ~f & p;
            default: return f ^ p;
        endcase
    endfunction

    function automatic logic [31:0] reg_of(input logic [1:0] a, input logic [W-1:0] d,
                                           input logic [W-1:0] m, input logic [W-1:0] c);
        logic [31:0] r;
        r = '0;
        case (a)
            2'd0: r[W-1:0] = d;
            2'd2: r[W-1:0] = m;
            2'd3: r[W-1:0] = c;
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        inq.delete();
        shq.delete();
        for (int i = 0; i < S; i++) inq.push_back('0);
        m_filt = '0; m_prev = '0; m_mask = '0; m_edges = 0;
        for (int k = 0; k < 3; k++) begin
            m_cap[k] = '0; m_irq[k] = 1'b0; m_rd[k] = '0;
        end
    endtask

    task automatic model_step();
        logic [W-1:0] sync_pre, filt_pre, det, clr, cap_n, mask_n;
        logic         wen;
        wen      = cs && wr;
        sync_pre = inq[0];
        filt_pre = m_filt;
        clr      = (wen && addr == 2'd3) ? wd[W-1:0] : '0;
        mask_n   = (wen && addr == 2'd2) ? wd[W-1:0] : m_mask;
        for (int k = 0; k < 3; k++) begin
            det      = (m_edges >= LAT) ? edge_of(k, filt_pre, m_prev) : '0;
            cap_n    = (m_cap[k] & ~clr) | det;
            m_rd[k]  = reg_of(addr, filt_pre, m_mask, m_cap[k]);
            m_irq[k] = |(cap_n & mask_n);
            m_cap[k] = cap_n;
        end
        m_mask = mask_n;
        m_prev = filt_pre;
        inq.push_back(inp);
        void'(inq.pop_front());
`ifdef NIOS_PIO_IN_DEBOUNCE_EN
        // a bit flips once the last D sampled sync values all disagree with it
        shq.push_back(sync_pre);
        if (shq.size() > D) void'(shq.pop_front());
        if (shq.size() == D) begin
            for (int b = 0; b < W; b++) begin
                logic other;
                other = 1'b1;
                foreach (shq[i]) if (shq[i][b] == m_filt[b]) other = 1'b0;
                if (other) m_filt[b] = ~m_filt[b];
            end
        end
`else
        m_filt = inq[0];
`endif
        m_edges++;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_step();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("model_rd%0d", k), rd_o[k], m_rd[k]);
            chk($sformatf("model_irq%0d", k), 32'(irq_o[k]), 32'(m_irq[k]));
        end
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        cs = 1'b1; wr = 1'b1; addr = a; wd = d;
        tick();
        cs = 1'b0; wr = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 2'd2, 32'hFFFF_F0F0, 32'h0,   1'b0};
        tbl[1]  = '{1'b1, 1'b0, 2'd2, 32'h0,         32'h0F0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 2'd0, 32'h0,         32'hFFF, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0,   1'b0};
        tbl[4]  = '{1'b1, 1'b0, 2'd3, 32'h0,         32'h0,   1'b0};
        tbl[5]  = '{1'b1, 1'b1, 2'd0, 32'h0,         32'hFFF, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 2'd2, 32'h0,         32'h0F0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 2'd2, 32'h0,         32'h0F0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 2'd2, 32'h0,         32'h0F0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 2'd2, 32'h0,         32'h0,   1'b0};
        tbl[10] = '{1'b1, 1'b0, 2'd1, 32'h0,         32'h0,   1'b0};

        model_reset();
        inp = 12'hFFF;
        repeat (3) tick();
        reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("reset_data", rd_o[0], (k >= S + DL + 1) ? 32'hFFF : 32'h0);
            chk("reset_irq", {29'b0, irq_o}, 32'h0);
        end

        foreach (tbl[i]) begin
            cs = tbl[i].cs; wr = tbl[i].wr; addr = tbl[i].a; wd = tbl[i].wd;
            tick();
            chk($sformatf("tbl%0d_rd", i), rd_o[0], tbl[i].rd);
            chk($sformatf("tbl%0d_irq", i), 32'(irq_o[0]), 32'(tbl[i].irq));
        end
        cs = 1'b0; wr = 1'b0;

        // rising capture, irq timing, W1C
        inp = '0;
        repeat (LAT + 2) tick();
        wr_reg(2'd3, 32'hFFF);
        wr_reg(2'd2, 32'h1);
        addr = 2'd3; inp = 12'h005;
        for (int k = 1; k <= LAT + 1; k++) begin
            tick();
            chk("cap_irq_rise", 32'(irq_o[0]), 32'(k >= LAT));
        end
        chk("cap_value", rd_o[0], 32'h005);
        wr_reg(2'd3, 32'h1);
        chk("w1c_irq", 32'(irq_o[0]), 32'h0);
        tick();
        chk("w1c_value", rd_o[0], 32'h004);

        // falling edge ignored by rising instance; set beats clear
        inp = 12'h001;
        repeat (LAT + 2) tick();
        chk("fall_ignored", rd_o[0], 32'h004);
        wr_reg(2'd3, 32'hFFF);
        tick();
        chk("cleared", rd_o[0], 32'h0);
        inp = 12'h005;
        repeat (LAT - 1) tick();
        wr_reg(2'd3, 32'h4);
        tick();
        chk("set_wins", rd_o[0], 32'h004);

        // any-edge instance: two toggles, irq held, mask drop
        wr_reg(2'd3, 32'hFFF);
        wr_reg(2'd2, 32'h1);
        addr = 2'd3; inp = 12'h004;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("any_irq_first", 32'(irq_o[2]), 32'(k >= LAT));
        end
        inp = 12'h005;
        for (int k = 1; k <= 2 * LAT; k++) begin
            tick();
            chk("any_irq_hold", 32'(irq_o[2]), 32'h1);
        end
        chk("any_cap", rd_o[2], 32'h1);
        wr_reg(2'd2, 32'h0);
        chk("any_mask_drop", 32'(irq_o[2]), 32'h0);

`ifdef NIOS_PIO_IN_DEBOUNCE_EN
        addr = 2'd0;
        tick();
        inp = 12'h007;
        for (int k = 1; k <= 2; k++) begin
            tick();
            chk("glitch_data", rd_o[0], 32'h005);
        end
        inp = 12'h005;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("glitch_data", rd_o[0], 32'h005);
        end
        addr = 2'd3;
        tick();
        chk("glitch_cap", rd_o[0] & 32'h2, 32'h0);
        addr = 2'd0; inp = 12'h007;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("deb_data", rd_o[0], (k >= S + D + 1) ? 32'h007 : 32'h005);
        end
        inp = 12'h005;
        repeat (LAT + 2) tick();
`endif

        // asynchronous reset with live capture and irq
        wr_reg(2'd3, 32'hFFF);
        inp = '0;
        repeat (LAT + 2) tick();
        wr_reg(2'd3, 32'hFFF);
        wr_reg(2'd2, 32'hFFF);
        addr = 2'd3; inp = 12'hABC;
        repeat (LAT + 1) tick();
        chk("pre_reset_cap", rd_o[0], 32'hABC);
        chk("pre_reset_irq", 32'(irq_o[0]), 32'h1);
        #2 reset = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("reset_async_rd", rd_o[k], 32'h0);
            chk("reset_async_irq", 32'(irq_o[k]), 32'h0);
        end
        repeat (2) tick();
        reset = 1'b0;
        repeat (LAT + 3) tick();
        chk("post_reset_cap", rd_o[0], 32'h0);
        chk("post_reset_irq", {29'b0, irq_o}, 32'h0);
        addr = 2'd2;
        tick();
        tick();
        chk("post_reset_mask", rd_o[0], 32'h0);

        // randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 7) == 0) inp = inp ^ W'($urandom);
            cs   = ($urandom_range(0, 3) != 0);
            wr   = ($urandom_range(0, 3) == 0);
            rd_s = $urandom_range(0, 1) == 1;
            addr = 2'($urandom);
            wd   = $urandom;
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b1;
                model_reset();
                tick();
                reset = 1'b0;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
